// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier among NREQ requesters,
// with operand capture, handshake sequencing and a done-watchdog.
module mult_share_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned W       = 24,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*W-1:0]   req_a,
   input  logic [NREQ*W-1:0]   req_b,
   output logic [NREQ-1:0]     grant,
   output logic [NREQ-1:0]     resp_valid,
   output logic [W-1:0]        resp_product,
   output logic                resp_err,
   output logic                busy,
   output logic [W-1:0]        mul_a,
   output logic [W-1:0]        mul_b,
   output logic                mul_available,
   output logic                mul_reset_n,
   input  logic                mul_status,
   input  logic                mul_done,
   input  logic [W-1:0]        mul_product
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   rr_ptr, owner, win;
   logic            win_vld;
   logic [CW-1:0]   wd_cnt;
   logic            wd_hit;
   logic            grant_q;
   logic            err_q;
   logic [NREQ-1:0] owner_oh;

   // First requester at or above rr_ptr, wrapping modulo NREQ.
   always_comb begin
      int unsigned   idx;
      logic [PW-1:0] cand;
      win     = '0;
      win_vld = 1'b0;
      idx     = 0;
      cand    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx  = (32'(rr_ptr) + k) % NREQ;
         cand = PW'(idx);
         if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win     = cand;
         end
      end
   end

   // A done arriving on the last allowed cycle wins over the abort.
   assign wd_hit = ((state == ISSUE) || ((state == WAIT) && !mul_done)) &&
                   (wd_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_vld) state_nxt = ISSUE;
         ISSUE:   if (wd_hit) state_nxt = RESP;
                  else if (mul_status) state_nxt = WAIT;
         WAIT:    if (mul_done || wd_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mul_a        <= '0;
         mul_b        <= '0;
         resp_product <= '0;
         owner        <= '0;
         rr_ptr       <= '0;
         wd_cnt       <= '0;
         grant_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         grant_q <= 1'b0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  mul_a   <= req_a[win*W +: W];
                  mul_b   <= req_b[win*W +: W];
                  owner   <= win;
                  rr_ptr  <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
                  grant_q <= 1'b1;
                  wd_cnt  <= '0;
               end
            end
            ISSUE, WAIT: begin
               wd_cnt <= wd_cnt + CW'(1);
               if ((state == WAIT) && mul_done) begin
                  resp_product <= mul_product;
                  err_q        <= 1'b0;
               end else if (wd_hit) begin
                  resp_product <= '0;
                  err_q        <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign owner_oh = NREQ'(1) << owner;

   always_comb begin
      grant         = '0;
      resp_valid    = '0;
      resp_err      = 1'b0;
      busy          = (state != IDLE);
      mul_available = (state == ISSUE);
      mul_reset_n   = ~reset & ~wd_hit;
      if (grant_q) grant = owner_oh;
      if (state == RESP) begin
         resp_valid = owner_oh;
         resp_err   = err_q;
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter against a Q1.23 shift-add multiplier
// model (accepts immediately, pulses done 26 cycles after acceptance).
module tb_mult_share_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [95:0] req_a, req_b;
   logic [3:0]  grant, resp_valid;
   logic [23:0] resp_product, mul_a, mul_b, mul_product;
   logic        resp_err, busy, mul_available, mul_reset_n, mul_status, mul_done;

   always #5 clk = ~clk;

   mult_share_arbiter #(.NREQ(4), .W(24), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
      .grant(grant), .resp_valid(resp_valid), .resp_product(resp_product),
      .resp_err(resp_err), .busy(busy), .mul_a(mul_a), .mul_b(mul_b),
      .mul_available(mul_available), .mul_reset_n(mul_reset_n),
      .mul_status(mul_status), .mul_done(mul_done), .mul_product(mul_product)
   );

   // Multiplier model: product computed from the live operand bus at done time.
   logic [5:0]  mcnt;
   logic        done_en;
   logic [47:0] full;
   always @(posedge clk) begin
      if (!mul_reset_n)                                  mcnt <= 6'd0;
      else if (mul_available && mul_status && mcnt == 0) mcnt <= 6'd1;
      else if (mcnt == 6'd26)                            mcnt <= 6'd0;
      else if (mcnt != 0)                                mcnt <= mcnt + 6'd1;
   end
   assign mul_status  = mul_available;
   assign mul_done    = done_en && (mcnt == 6'd26);
   assign full        = {24'd0, mul_a} * {24'd0, mul_b};
   assign mul_product = full[46:23];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_grant(input int limit, output logic [3:0] g, output int at);
      g = '0; at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (grant != 0) begin g = grant; at = cyc; return; end
      end
   endtask

   task automatic wait_resp(input int limit, output logic [3:0] r, output int at);
      r = '0; at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (resp_valid != 0) begin r = resp_valid; at = cyc; return; end
      end
   endtask

   typedef struct {
      int          idx;
      logic [23:0] a;
      logic [23:0] b;
      logic [23:0] p;
   } vec_t;

   vec_t        vecs[7];
   logic [23:0] rr_a[4], rr_b[4], rr_p[4];

   initial begin
      logic [3:0] g, r, oh;
      int at, rat, t0, prev, avail, lowcnt, lowat, stray;

      vecs[0] = '{0, 24'h400000, 24'h200000, 24'h100000};
      vecs[1] = '{1, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFE};
      vecs[2] = '{2, 24'h800000, 24'h123456, 24'h123456};
      vecs[3] = '{3, 24'hFFFFFF, 24'h800000, 24'hFFFFFF};
      vecs[4] = '{1, 24'h000000, 24'h555555, 24'h000000};
      vecs[5] = '{2, 24'h600000, 24'h600000, 24'h480000};
      vecs[6] = '{3, 24'h000001, 24'hFFFFFF, 24'h000001};
      rr_a = '{24'h400000, 24'h600000, 24'h800000, 24'h7FFFFF};
      rr_b = '{24'h200000, 24'h600000, 24'h123456, 24'h7FFFFF};
      rr_p = '{24'h100000, 24'h480000, 24'h123456, 24'h7FFFFE};

      reset = 1'b1; req = '0; req_a = '0; req_b = '0; done_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mul_available", mul_available, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_resp_product", resp_product, 0);
      chk("rst_mul_reset_n", mul_reset_n, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("mul_reset_n_release", mul_reset_n, 1);

      // Single-request vectors: latency, handshake width and product.
      for (int v = 0; v < 7; v++) begin
         oh = 4'b0001 << vecs[v].idx;
         req = oh;
         req_a[vecs[v].idx*24 +: 24] = vecs[v].a;
         req_b[vecs[v].idx*24 +: 24] = vecs[v].b;
         t0 = cyc;
         wait_grant(5, g, at);
         chk("vec_grant", g, oh);
         chk("vec_grant_lat", at - t0, 1);
         req = '0;
         avail = mul_available ? 1 : 0;
         rat = -1; r = '0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mul_available) avail++;
            if (resp_valid != 0) begin r = resp_valid; rat = cyc; break; end
         end
         chk("vec_resp_valid", r, oh);
         chk("vec_resp_lat", rat - t0, 28);
         chk("vec_product", resp_product, vecs[v].p);
         chk("vec_err", resp_err, 0);
         chk("vec_avail_cycles", avail, 1);
         @(negedge clk);
         chk("vec_idle_after", busy, 0);
      end

      // Round-robin with all four requesting.
      for (int i = 0; i < 4; i++) begin
         req_a[i*24 +: 24] = rr_a[i];
         req_b[i*24 +: 24] = rr_b[i];
      end
      req = 4'b1111;
      prev = -1;
      for (int k = 0; k < 5; k++) begin
         wait_grant(80, g, at);
         chk("rr_grant", g, 4'b0001 << (k % 4));
         if (k > 0) chk("rr_spacing", at - prev, 29);
         prev = at;
         if (k == 4) req = '0;
         wait_resp(80, r, rat);
         chk("rr_resp_owner", r, 4'b0001 << (k % 4));
         chk("rr_product", resp_product, rr_p[k % 4]);
      end

      // Pointer wrap: serve 3, then 0 and 3 both pending.
      @(negedge clk);
      req = 4'b1000;
      wait_grant(10, g, at);
      chk("wrap_grant3", g, 4'b1000);
      req = '0;
      wait_resp(40, r, rat);
      req = 4'b1001;
      wait_grant(10, g, at);
      chk("wrap_grant0", g, 4'b0001);
      req = 4'b1000;
      wait_resp(40, r, rat);
      chk("wrap_resp0", r, 4'b0001);
      wait_grant(10, g, at);
      chk("wrap_grant3b", g, 4'b1000);
      req = '0;
      wait_resp(40, r, rat);
      chk("wrap_resp3", r, 4'b1000);
      chk("wrap_product3", resp_product, 24'h7FFFFE);

      // Operand hold: requester changes its operand while the multiply runs.
      @(negedge clk);
      req_a[24 +: 24] = 24'h400000;
      req_b[24 +: 24] = 24'h400000;
      req = 4'b0010;
      wait_grant(10, g, at);
      chk("hold_grant", g, 4'b0010);
      req = '0;
      repeat (5) @(negedge clk);
      req_a[24 +: 24] = 24'h7FFFFF;
      @(negedge clk);
      chk("hold_mul_a", mul_a, 24'h400000);
      wait_resp(40, r, rat);
      chk("hold_resp", r, 4'b0010);
      chk("hold_product", resp_product, 24'h200000);

      // Reset in the 10th WAIT cycle, then rr_ptr must be back at 0.
      @(negedge clk);
      req_a[24 +: 24] = 24'h600000;
      req_b[24 +: 24] = 24'h600000;
      req = 4'b0010;
      wait_grant(10, g, at);
      req = '0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_grant", grant, 0);
      chk("mid_rst_resp_valid", resp_valid, 0);
      chk("mid_rst_mul_a", mul_a, 0);
      chk("mid_rst_mul_b", mul_b, 0);
      chk("mid_rst_resp_product", resp_product, 0);
      chk("mid_rst_mul_reset_n", mul_reset_n, 0);
      reset = 1'b0;
      stray = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (resp_valid != 0) stray++;
      end
      chk("mid_rst_no_resp", stray, 0);
      req_a[0 +: 24]  = 24'h400000; req_b[0 +: 24]  = 24'h200000;
      req_a[48 +: 24] = 24'h800000; req_b[48 +: 24] = 24'h123456;
      req = 4'b0101;
      wait_grant(10, g, at);
      chk("post_rst_ptr_grant", g, 4'b0001);
      req = 4'b0100;
      wait_resp(40, r, rat);
      chk("post_rst_product0", resp_product, 24'h100000);
      wait_grant(10, g, at);
      chk("post_rst_grant2", g, 4'b0100);
      req = '0;
      wait_resp(40, r, rat);
      chk("post_rst_resp2", r, 4'b0100);
      chk("post_rst_product2", resp_product, 24'h123456);

      // Watchdog: multiplier never signals done.
      @(negedge clk);
      done_en = 1'b0;
      req = 4'b0001;
      t0 = cyc;
      wait_grant(10, g, at);
      req = '0;
      lowcnt = 0; lowat = -1; rat = -1; r = '0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!mul_reset_n) begin lowcnt++; if (lowat < 0) lowat = cyc; end
         if (resp_valid != 0) begin r = resp_valid; rat = cyc; break; end
      end
      chk("wd_reset_n_cycles", lowcnt, 1);
      chk("wd_reset_n_at", lowat - t0, 64);
      chk("wd_resp_at", rat - t0, 65);
      chk("wd_resp_owner", r, 4'b0001);
      chk("wd_resp_err", resp_err, 1);
      chk("wd_resp_product", resp_product, 0);
      @(negedge clk);
      chk("wd_idle_after", busy, 0);
      done_en = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one 24-bit shift-add Multiplier instance between NREQ audio-path requesters, such as gain, mix and filter-tap stages.
- Arbitration is round-robin. The block captures the winner's operands and drives the multiplier's available/status/done handshake, holding the operands stable for the whole computation.
- The product is returned to the owning requester with a one-cycle response pulse.
- A watchdog recovers from a multiplier that never signals done.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 24, operand and product width.
- TIMEOUT, 64, maximum cycles spent in ISSUE+WAIT before abort (must be > 30).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- req_a  in  NREQ*W  packed operand A; slice i belongs to requester i.
- req_b  in  NREQ*W  packed operand B; slice i belongs to requester i.
- grant  out  NREQ  one-hot, one-cycle pulse: operands of requester i accepted.
- resp_valid  out  NREQ  one-hot, one-cycle pulse: result for requester i.
- resp_product  out  W  product; valid only while resp_valid is nonzero.
- resp_err  out  1  qualifies resp_valid; 1 = watchdog abort, resp_product = 0.
- busy  out  1  high whenever state is not IDLE.
- mul_a  out  W  operand A to Multiplier.
- mul_b  out  W  operand B to Multiplier.
- mul_available  out  1  start request to Multiplier.
- mul_reset_n  out  1  active-low reset to Multiplier.
- mul_status  in  1  Multiplier accepted the request.
- mul_done  in  1  Multiplier result-ready pulse.
- mul_product  in  W  Multiplier result.

Behaviour:
- Reset values:
  - State IDLE.
  - grant, resp_valid, resp_err, busy, mul_available all 0.
  - resp_product, mul_a, mul_b all 0.
  - rr_ptr = 0; watchdog counter = 0.
  - mul_reset_n = ~reset (combinational), so the Multiplier resets in the same cycles.
- Reset mid-operation abandons the transaction. No response is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0, pick the winner: first set bit scanning from rr_ptr upward, wrapping modulo NREQ.
  - Register the winner's req_a/req_b into mul_a/mul_b and record owner.
  - Set rr_ptr = (winner+1) mod NREQ.
  - Next cycle: grant[owner]=1 for exactly that cycle, state ISSUE.
  - With req == 0, remain in IDLE.
- ISSUE: mul_available=1. When mul_status=1, go to WAIT; mul_available drops in the WAIT cycle.
- WAIT:
  - mul_a/mul_b are held unchanged, because the Multiplier samples its operands on every calculating cycle.
  - On mul_done=1, register mul_product into resp_product and go to RESP.
- RESP: resp_valid[owner]=1 and resp_err=0 for one cycle, then IDLE.
- mul_a/mul_b keep their last value in IDLE and RESP. They change only on a new capture.
- Watchdog:
  - Counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - If it reaches TIMEOUT-1 without mul_done: drive mul_reset_n=0 for one cycle, then enter RESP with resp_err=1 and resp_product=0.
- Nominal latency with the team Multiplier: req sampled in IDLE at cycle 0 → grant at 1 → resp_valid at 28. Back-to-back issue rate is one operation per 29 cycles.
- Requester rules:
  - Hold req_a/req_b stable while req is high, until grant.
  - May keep req high to queue another operation; it will not be re-granted before other pending requesters are served.
- Arbitration happens only in IDLE. Requests arriving in other states wait.
- mul_done or mul_status outside WAIT/ISSUE is ignored.
- A requester deasserting req after grant does not cancel its operation. Its resp_valid is still issued.
- Simultaneous requests: exactly one grant per arbitration. No requester is starved; worst-case wait is (NREQ-1) operations.

Test Plan:
- Single request: req=4'b0001 for one cycle, a=24'h400000, b=24'h200000 → grant[0] at cycle 1, mul_available high for 1 cycle, resp_valid=4'b0001 at cycle 28, resp_product equals the Multiplier's product for those operands, resp_err=0.
- Round-robin: req=4'b1111 held, distinct operands per requester → grants in order 0,1,2,3,0; each resp_valid goes to the matching owner with the correct product; grants spaced 29 cycles apart.
- Pointer wrap: after serving requester 3, req=4'b1001 → requester 0 granted next, then 3.
- Operand hold: change req_a[1] after grant[1] while in WAIT → mul_a unchanged, result uses the captured value.
- Watchdog: tie mul_done=0 with TIMEOUT=64 → mul_reset_n low for exactly one cycle, then resp_valid[owner]=1 with resp_err=1 and resp_product=0, then IDLE.
- Reset mid-operation: assert reset at cycle 10 of WAIT → all outputs reach reset values next cycle, no resp_valid, rr_ptr=0; a following req=4'b0100 is granted normally.
